// File: rtl/pcm_pkg.sv
// pcm_pkg -- shared definitions for the PCM sigma-delta output block.
//   pcm_state_e      : frame sequencer states (IDLE, FETCH, CAPTURE, LOAD)
//   PCM_DATA_W_DEF   : default sample width in bits
//   PCM_DIV_DEF      : default clk96m cycles per frame (96 MHz / 48 kHz)
//   PCM_CHANNELS_DEF : default number of interleaved channels
package pcm_pkg;

  localparam int PCM_DATA_W_DEF   = 16;
  localparam int PCM_DIV_DEF      = 2000;
  localparam int PCM_CHANNELS_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_CAPTURE = 2'd2,
    S_LOAD    = 2'd3
  } pcm_state_e;

endpackage

// File: rtl/pcm_stream_out_sd_dac1.sv
// sd_dac1 -- single-channel first-order sigma-delta modulator.
// Optional feature macro: PCM_VOLUME_EN (arithmetic right shift of the sample
// by min(volume, DATA_W-1) before modulation). Without it volume is ignored.
// Ports:
//   clk96m  in   system clock
//   rst     in   synchronous active-high reset (clears the accumulator)
//   sample  in   signed two's-complement sample, held between frames
//   volume  in   attenuation shift amount
//   dac_out out  1-bit density-modulated stream
module sd_dac1 #(
  parameter int DATA_W = 16
) (
  input  logic              clk96m,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic [3:0]        volume,
  output logic              dac_out
);

  logic signed [DATA_W-1:0] shifted;
  logic        [DATA_W-1:0] offset;
  logic        [DATA_W:0]   acc;

`ifdef PCM_VOLUME_EN
  always_comb begin
    shifted = $signed(sample);
    if ({28'd0, volume} > 32'(DATA_W - 1))
      shifted = $signed(sample) >>> (DATA_W - 1);
    else
      shifted = $signed(sample) >>> volume;
  end
`else
  logic unused_volume;
  assign unused_volume = ^volume;
  assign shifted = $signed(sample);
`endif

  // Inverting the MSB maps signed full scale onto 0..2^DATA_W-1, so the
  // carry-out density equals (sample + half scale) / full scale.
  assign offset = {~shifted[DATA_W-1], shifted[DATA_W-2:0]};

  always_ff @(posedge clk96m) begin
    if (rst) acc <= '0;
    else     acc <= {1'b0, acc[DATA_W-1:0]} + {1'b0, offset};
  end

  assign dac_out = acc[DATA_W];

endmodule

// File: rtl/pcm_stream_out.sv
// pcm_stream_out -- frame-paced PCM reader driving per-channel sigma-delta DACs.
// Optional feature macro: PCM_VOLUME_EN (volume attenuation inside sd_dac1).
// Ports:
//   clk96m       in   96 MHz system clock
//   rst          in   synchronous active-high reset
//   enable       in   playback enable; low holds the frame counter at 0
//   fifo_empty   in   upstream FIFO empty flag
//   fifo_rd_en   out  one-cycle FIFO read strobe (data returns next cycle)
//   fifo_data    in   FIFO read data
//   volume       in   attenuation shift amount
//   sample_tick  out  one-cycle pulse at each frame start
//   dac_out      out  per-channel 1-bit streams
//   underrun     out  one-cycle pulse after a frame with a missing sample
//   underrun_cnt out  saturating count of underrun frames
//   state        out  sequencer state (debug visibility)
//   active       out  active samples, channel c at [c*DATA_W +: DATA_W] (debug)
// Handshake: a read is issued only when fifo_empty was low on the cycle the
// sequencer entered FETCH; fifo_rd_en is then high for exactly that FETCH
// cycle and fifo_data is taken in the following CAPTURE cycle.
module pcm_stream_out
  import pcm_pkg::*;
#(
  parameter int DATA_W   = PCM_DATA_W_DEF,
  parameter int CHANNELS = PCM_CHANNELS_DEF,
  parameter int DIV      = PCM_DIV_DEF
) (
  input  logic                       clk96m,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [DATA_W-1:0]          fifo_data,
  input  logic [3:0]                 volume,
  output logic                       sample_tick,
  output logic [CHANNELS-1:0]        dac_out,
  output logic                       underrun,
  output logic [15:0]                underrun_cnt,
  output pcm_state_e                 state,
  output logic [CHANNELS*DATA_W-1:0] active
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              read_q;
  logic              underrun_flag;
  logic              enter_fetch;
  logic [DATA_W-1:0] shadow   [CHANNELS];
  logic [DATA_W-1:0] active_q [CHANNELS];

  // Frame pacing counter.
  always_ff @(posedge clk96m) begin
    if (rst || !enable)       cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign sample_tick = !rst && enable && (cnt == CNT_LAST);

  // A tick outside IDLE is simply not looked at, so it is dropped.
  assign enter_fetch = ((state == S_IDLE) && sample_tick) ||
                       ((state == S_CAPTURE) && (idx != IDX_LAST));

  always_ff @(posedge clk96m) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      fifo_rd_en    <= 1'b0;
      read_q        <= 1'b0;
      underrun_flag <= 1'b0;
      underrun      <= 1'b0;
      underrun_cnt  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        shadow[c]   <= '0;
        active_q[c] <= '0;
      end
    end else begin
      fifo_rd_en <= 1'b0;
      underrun   <= 1'b0;

      // The empty flag is sampled on the way into FETCH so the read strobe
      // can be a clean register during the FETCH cycle itself.
      if (enter_fetch) begin
        fifo_rd_en <= !fifo_empty;
        read_q     <= !fifo_empty;
        if (fifo_empty) underrun_flag <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            idx   <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          shadow[idx] <= read_q ? fifo_data : '0;
          if (idx == IDX_LAST) begin
            state <= S_LOAD;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end
        S_LOAD: begin
          for (int c = 0; c < CHANNELS; c++) active_q[c] <= shadow[c];
          underrun      <= underrun_flag;
          underrun_flag <= 1'b0;
          if (underrun_flag && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_dac
    sd_dac1 #(.DATA_W(DATA_W)) u_dac (
      .clk96m  (clk96m),
      .rst     (rst),
      .sample  (active_q[c]),
      .volume  (volume),
      .dac_out (dac_out[c])
    );
    assign active[c*DATA_W +: DATA_W] = active_q[c];
  end

endmodule

// File: tb/tb_pcm_stream_out.sv
// tb_pcm_stream_out -- directed bench for pcm_stream_out (DIV=20, CHANNELS=2).
// Expected density depends on PCM_VOLUME_EN: volume is driven to 1 during the
// density measurement, giving 62.5% with the feature and 75% without it.
module tb_pcm_stream_out;
  import pcm_pkg::*;

  localparam int DATA_W   = 16;
  localparam int CHANNELS = 2;
  localparam int DIV      = 20;

  // clock / reset
  logic clk96m = 1'b0;
  logic rst    = 1'b1;
  always #5 clk96m = ~clk96m;

  logic                       enable = 1'b0;
  logic                       fifo_empty;
  logic                       fifo_rd_en;
  logic [DATA_W-1:0]          fifo_data = '0;
  logic [3:0]                 volume = 4'd0;
  logic                       sample_tick;
  logic [CHANNELS-1:0]        dac_out;
  logic                       underrun;
  logic [15:0]                underrun_cnt;
  pcm_state_e                 state;
  logic [CHANNELS*DATA_W-1:0] active;

  pcm_stream_out #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .DIV(DIV)) dut (
    .clk96m       (clk96m),
    .rst          (rst),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_data    (fifo_data),
    .volume       (volume),
    .sample_tick  (sample_tick),
    .dac_out      (dac_out),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .state        (state),
    .active       (active)
  );

  // upstream FIFO: data appears the cycle after the read strobe
  logic [DATA_W-1:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk96m) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_data <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // scoreboard counters
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push(input logic [DATA_W-1:0] d);
    mem[wr_ptr % 16] = d;
    wr_ptr++;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (sample_tick !== 1'b1 && n < 4 * DIV) begin
      @(negedge clk96m);
      n++;
    end
    check("tick_seen", {63'd0, sample_tick}, 64'd1);
  endtask

  // Observes the 6 cycles after a tick: FETCH,CAPTURE,FETCH,CAPTURE,LOAD,IDLE.
  task automatic run_frame(output int wait_n, output int rd_n, output int ur_n,
                           output pcm_state_e st5);
    wait_tick(wait_n);
    rd_n = 0;
    ur_n = 0;
    st5  = S_IDLE;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk96m);
      rd_n += int'(fifo_rd_en);
      ur_n += int'(underrun);
      if (i == 5) st5 = state;
    end
  endtask

  int         wait_n, rd_n, ur_n, ones0, ones1, ticks_off, loads, exp_ones;
  pcm_state_e st5;

  initial begin
    // reset state
    repeat (3) @(negedge clk96m);
    check("rst_state", 64'(state), 64'(S_IDLE));
    check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("rst_tick", {63'd0, sample_tick}, 64'd0);
    check("rst_underrun", {63'd0, underrun}, 64'd0);
    check("rst_dac", 64'(dac_out), 64'd0);
    check("rst_ucnt", 64'(underrun_cnt), 64'd0);
    check("rst_active", 64'(active), 64'd0);

    // reset during CAPTURE of ch0 with an empty FIFO: frame must be aborted
    rst = 1'b0;
    enable = 1'b1;
    wait_tick(wait_n);
    check("first_tick_latency", 64'(wait_n), 64'(DIV - 1));
    @(negedge clk96m);
    check("abort_fetch_state", 64'(state), 64'(S_FETCH));
    check("abort_no_read_empty", {63'd0, fifo_rd_en}, 64'd0);
    @(negedge clk96m);
    check("abort_capture_state", 64'(state), 64'(S_CAPTURE));
    rst = 1'b1;
    @(negedge clk96m);
    check("abort_state", 64'(state), 64'(S_IDLE));
    check("abort_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("abort_underrun", {63'd0, underrun}, 64'd0);
    check("abort_dac", 64'(dac_out), 64'd0);
    check("abort_tick", {63'd0, sample_tick}, 64'd0);
    rst = 1'b0;
    loads = 0;
    ur_n  = 0;
    repeat (8) begin
      @(negedge clk96m);
      loads += (state == S_LOAD) ? 1 : 0;
      ur_n  += int'(underrun);
    end
    check("abort_no_load", 64'(loads), 64'd0);
    check("abort_no_underrun", 64'(ur_n), 64'd0);
    check("abort_ucnt", 64'(underrun_cnt), 64'd0);

    // two samples available
    push(16'h1234);
    push(16'h5678);
    run_frame(wait_n, rd_n, ur_n, st5);
    check("full_rd_pulses", 64'(rd_n), 64'd2);
    check("full_load_at_tick5", 64'(st5), 64'(S_LOAD));
    check("full_active", 64'(active), 64'h5678_1234);
    check("full_underrun", 64'(ur_n), 64'd0);
    check("full_ucnt", 64'(underrun_cnt), 64'd0);

    // empty FIFO
    run_frame(wait_n, rd_n, ur_n, st5);
    check("empty_period", 64'(wait_n), 64'(DIV - 6));
    check("empty_rd_pulses", 64'(rd_n), 64'd0);
    check("empty_active", 64'(active), 64'd0);
    check("empty_underrun", 64'(ur_n), 64'd1);
    check("empty_ucnt", 64'(underrun_cnt), 64'd1);

    // one sample only
    push(16'hABCD);
    run_frame(wait_n, rd_n, ur_n, st5);
    check("one_period", 64'(wait_n), 64'(DIV - 6));
    check("one_rd_pulses", 64'(rd_n), 64'd1);
    check("one_active", 64'(active), 64'h0000_ABCD);
    check("one_underrun", 64'(ur_n), 64'd1);
    check("one_ucnt", 64'(underrun_cnt), 64'd2);

    // constant 16'h4000 on both channels, then hold with playback disabled
    push(16'h4000);
    push(16'h4000);
    run_frame(wait_n, rd_n, ur_n, st5);
    check("dens_active", 64'(active), 64'h4000_4000);
    check("dens_underrun", 64'(ur_n), 64'd0);
    enable = 1'b0;
    volume = 4'd1;
`ifdef PCM_VOLUME_EN
    exp_ones = 640;
`else
    exp_ones = 768;
`endif
    ones0 = 0;
    ones1 = 0;
    ticks_off = 0;
    repeat (1024) begin
      @(negedge clk96m);
      ones0     += int'(dac_out[0]);
      ones1     += int'(dac_out[1]);
      ticks_off += int'(sample_tick);
    end
    check("dens_ch0_in_range",
          {63'd0, (ones0 >= exp_ones - 1 && ones0 <= exp_ones + 1)}, 64'd1);
    check("dens_ch1_in_range",
          {63'd0, (ones1 >= exp_ones - 1 && ones1 <= exp_ones + 1)}, 64'd1);
    if (!(ones0 >= exp_ones - 1 && ones0 <= exp_ones + 1))
      $display("density ch0 ones=%0d target=%0d", ones0, exp_ones);
    check("disabled_no_tick", 64'(ticks_off), 64'd0);
    check("disabled_state", 64'(state), 64'(S_IDLE));

    // saturation of the underrun counter
    volume = 4'd0;
    enable = 1'b1;
    force dut.underrun_cnt = 16'hFFFF;
    @(negedge clk96m);
    release dut.underrun_cnt;
    run_frame(wait_n, rd_n, ur_n, st5);
    check("sat_underrun", 64'(ur_n), 64'd1);
    check("sat_ucnt", 64'(underrun_cnt), 64'hFFFF);
    run_frame(wait_n, rd_n, ur_n, st5);
    check("sat_underrun2", 64'(ur_n), 64'd1);
    check("sat_ucnt2", 64'(underrun_cnt), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
